axis_sample_source: RTL and testbench

AXI4-Stream master that plays a preloaded buffer of signed samples at a fixed sample rate derived from the system clock. It is the transmitting end of the filter's `s_axis` input: it stands in for an ADC front end or DMA source ahead of the biquad chain, in hardware and in benches. Backpressure is handled AXIS-compliantly. Sample-rate slips are counted, never hidden.

---
 rtl/axis_sample_source.sv | 123 ++++++++++++
 tb/tb_axis_sample_source.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_sample_source.sv
// AXIS master replaying a preloaded sample buffer, one beat per clks_per_sample tick; first beat one clock after start.
// A stalled beat is held unchanged and each tick that finds it still stalled bumps the saturating overrun counter.
module axis_sample_source #(
    parameter int data_width      = 16,
    parameter int depth           = 256,
    parameter int clks_per_sample = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [$clog2(depth)-1:0]   wr_addr,
    input  logic [data_width-1:0]      wr_data,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       loop,
    input  logic [$clog2(depth):0]     num_samples,
    output logic [data_width-1:0]      m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic                       busy,
    output logic                       done,
    output logic [15:0]                overrun_cnt
);
    localparam int aw  = $clog2(depth);
    localparam int dvw = $clog2(clks_per_sample);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               state;
    logic [data_width-1:0] mem [depth];
    logic [aw-1:0]        idx;
    logic [aw-1:0]        n_last;
    logic [dvw-1:0]       div;
    logic                 loop_q;
    logic                 stopping;
    logic [aw:0]          n_eff;
    logic                 tick;
    logic                 accept;

    // Buffer is deliberately not reset so a replay after reset uses the same data.
    always_ff @(posedge clk) begin
        if (wr_en && state == S_IDLE)
            mem[wr_addr] <= wr_data;
    end

    always_comb begin
        n_eff = num_samples;
        if (num_samples == '0 || num_samples > (aw+1)'(depth))
            n_eff = (aw+1)'(depth);
    end

    assign tick   = (state == S_RUN) && (div == '0);
    assign accept = m_axis_tvalid && m_axis_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            idx           <= '0;
            n_last        <= '0;
            div           <= '0;
            loop_q        <= 1'b0;
            stopping      <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            overrun_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state       <= S_RUN;
                        busy        <= 1'b1;
                        idx         <= '0;
                        div         <= '0;
                        loop_q      <= loop;
                        n_last      <= aw'(n_eff - 1'b1);
                        stopping    <= 1'b0;
                        overrun_cnt <= '0;
                    end
                end
                S_RUN: begin
                    div <= (div == dvw'(clks_per_sample - 1)) ? '0 : div + 1'b1;
                    // Abort waits for any pending beat to handshake before finishing.
                    if (stop || stopping) begin
                        if (!m_axis_tvalid || m_axis_tready) begin
                            m_axis_tvalid <= 1'b0;
                            state         <= S_DONE;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                        end else begin
                            stopping <= 1'b1;
                        end
                    end else if (accept && m_axis_tlast && !loop_q) begin
                        m_axis_tvalid <= 1'b0;
                        state         <= S_DONE;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                    end else if (tick) begin
                        if (!m_axis_tvalid || m_axis_tready) begin
                            m_axis_tdata  <= mem[idx];
                            m_axis_tvalid <= 1'b1;
                            m_axis_tlast  <= (idx == n_last);
                            idx           <= (idx == n_last) ? '0 : idx + 1'b1;
                        end else if (overrun_cnt != 16'hFFFF) begin
                            overrun_cnt <= overrun_cnt + 16'd1;
                        end
                    end else if (accept) begin
                        m_axis_tvalid <= 1'b0;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_sample_source.sv
// Bench for axis_sample_source: scoreboard of expected beats plus a table of pass lengths and timed corner sequences.
module tb_axis_sample_source;
    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        start;
    logic        stop;
    logic        loop;
    logic [8:0]  num_samples;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        busy;
    logic        done;
    logic [15:0] overrun_cnt;

    axis_sample_source dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .stop(stop), .loop(loop), .num_samples(num_samples),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .busy(busy), .done(done), .overrun_cnt(overrun_cnt)
    );

    typedef struct packed { logic [15:0] d; logic l; } beat_t;
    typedef struct { int num; bit wr_run; int exp_beats; } vec_t;

    beat_t       sb[$];
    beat_t       exp_b;
    logic [15:0] ref_mem [256];
    vec_t        vecs [6];
    int          checks = 0;
    int          errors = 0;
    int          n_acc  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Beats are sampled just before the rising edge that accepts them.
    always @(negedge clk) begin
        #4;
        if (rst_n && m_axis_tvalid && m_axis_tready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL beat: unexpected beat data %0d, none expected", m_axis_tdata);
            end else begin
                exp_b = sb.pop_front();
                chk("beat tdata", {16'd0, m_axis_tdata}, {16'd0, exp_b.d});
                chk("beat tlast", {31'd0, m_axis_tlast}, {31'd0, exp_b.l});
            end
            n_acc++;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = 8'(a); wr_data = d; ref_mem[a] = d;
        step;
        wr_en = 1'b0;
    endtask

    task automatic write_only(input int a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = 8'(a); wr_data = d;
        step;
        wr_en = 1'b0;
    endtask

    task automatic push_beats(input int n_eff, input int count);
        for (int i = 0; i < count; i++) begin
            int k;
            k = i % n_eff;
            sb.push_back({ref_mem[k], (k == n_eff - 1) ? 1'b1 : 1'b0});
        end
    endtask

    task automatic start_play(input int n, input bit lp);
        start = 1'b1; loop = lp; num_samples = 9'(n);
        step;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: done not seen within %0d cycles", nm, max);
        end else begin
            chk({nm, " busy at done"}, {31'd0, busy}, 32'd0);
        end
        step;
    endtask

    initial begin
        int base;
        int exp_ovr;
        int vcnt;
        bit seen;

        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; stop = 1'b0; loop = 1'b0; num_samples = '0; m_axis_tready = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        vecs[0] = '{0,   1'b1, 256};
        vecs[1] = '{256, 1'b0, 256};
        vecs[2] = '{300, 1'b0, 256};
        vecs[3] = '{1,   1'b0, 1};
        vecs[4] = '{2,   1'b0, 2};
        vecs[5] = '{5,   1'b0, 5};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("reset tdata", {16'd0, m_axis_tdata}, 32'd0);
        chk("reset tlast", {31'd0, m_axis_tlast}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset overrun", {16'd0, overrun_cnt}, 32'd0);
        step;
        rst_n = 1'b1;
        step;

        // Basic pass: beats after E1, E6, E11, E16, done after the last acceptance.
        load(0, 16'd100); load(1, -16'sd200); load(2, 16'd300); load(3, -16'sd400);
        push_beats(4, 4);
        base = n_acc;
        start_play(4, 1'b0);
        @(negedge clk);
        chk("busy after start", {31'd0, busy}, 32'd1);
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("tvalid E%0d", k), {31'd0, m_axis_tvalid},
                {31'd0, (((k - 1) % 5 == 0) && k <= 16)});
            chk($sformatf("done E%0d", k), {31'd0, done}, {31'd0, (k == 17)});
        end
        step;
        chk("basic beats", n_acc - base, 32'd4);
        chk("basic overrun", {16'd0, overrun_cnt}, 32'd0);

        // Stall from E2 to E13: first beat held, two slipped ticks, no loss.
        push_beats(4, 4);
        base = n_acc;
        start_play(4, 1'b0);
        step;
        m_axis_tready = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            chk($sformatf("stall tvalid E%0d", k), {31'd0, m_axis_tvalid}, 32'd1);
            chk($sformatf("stall tdata E%0d", k), {16'd0, m_axis_tdata}, 32'd100);
            if (k < 13) @(posedge clk);
        end
        #1 m_axis_tready = 1'b1;
        step;
        wait_done(100, "stall");
        chk("stall overrun", {16'd0, overrun_cnt}, 32'd2);
        chk("stall beats", n_acc - base, 32'd4);

        // Loop over three samples, then stop while the second sample of pass three stalls.
        load(0, 16'd1); load(1, 16'd2); load(2, 16'd3);
        push_beats(3, 8);
        base = n_acc;
        start_play(3, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (n_acc - base == 7) begin seen = 1'b1; break; end
            step;
        end
        chk("loop seven beats reached", {31'd0, seen}, 32'd1);
        m_axis_tready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (m_axis_tvalid) begin seen = 1'b1; break; end
            step;
        end
        chk("loop stalled beat present", {31'd0, seen}, 32'd1);
        stop = 1'b1;
        step;
        stop = 1'b0;
        repeat (3) step;
        @(negedge clk);
        chk("stop busy while pending", {31'd0, busy}, 32'd1);
        chk("stop tdata held", {16'd0, m_axis_tdata}, 32'd2);
        step;
        m_axis_tready = 1'b1;
        wait_done(20, "stop");
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_axis_tvalid) vcnt++;
        end
        step;
        chk("no beats after stop", vcnt, 32'd0);
        chk("loop beats", n_acc - base, 32'd8);

        // Pass-length table over an impulse buffer; the first row also writes during RUN.
        for (int a = 0; a < 256; a++) load(a, (a == 0) ? 16'd32767 : 16'd0);
        for (int v = 0; v < 6; v++) begin
            push_beats(vecs[v].exp_beats, vecs[v].exp_beats);
            base = n_acc;
            start_play(vecs[v].num, 1'b0);
            if (vecs[v].wr_run) begin
                repeat (3) step;
                write_only(0, 16'd5);
                write_only(7, 16'd1234);
            end
            wait_done(3000, $sformatf("table row %0d", v));
            chk($sformatf("table row %0d beats", v), n_acc - base, vecs[v].exp_beats);
            chk($sformatf("table row %0d leftover", v), sb.size(), 32'd0);
        end

        // Asynchronous reset with a beat pending, then identical replay.
        load(0, 16'd100); load(1, -16'sd200); load(2, 16'd300); load(3, -16'sd400);
        start_play(4, 1'b0);
        step;
        m_axis_tready = 1'b0;
        @(negedge clk);
        chk("pre-reset tvalid", {31'd0, m_axis_tvalid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid-run reset tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("mid-run reset busy", {31'd0, busy}, 32'd0);
        chk("mid-run reset tdata", {16'd0, m_axis_tdata}, 32'd0);
        step;
        rst_n = 1'b1;
        m_axis_tready = 1'b1;
        step;
        push_beats(4, 4);
        base = n_acc;
        start_play(4, 1'b0);
        wait_done(100, "replay");
        chk("replay beats", n_acc - base, 32'd4);

        // Forty-cycle stall: expected slips are the ticks landing on stalled edges E2..E41.
        push_beats(4, 4);
        base = n_acc;
        start_play(4, 1'b0);
        step;
        m_axis_tready = 1'b0;
        repeat (40) step;
        m_axis_tready = 1'b1;
        exp_ovr = 0;
        for (int e = 2; e <= 41; e++) if ((e - 1) % 5 == 0) exp_ovr++;
        wait_done(200, "long stall");
        chk("long stall overrun", {16'd0, overrun_cnt}, exp_ovr);
        chk("long stall beats", n_acc - base, 32'd4);

        // Saturation: preset the counter near full and keep stalling.
        push_beats(4, 1);
        start_play(4, 1'b1);
        step;
        m_axis_tready = 1'b0;
        repeat (3) step;
        @(negedge clk);
        force dut.overrun_cnt = 16'd65533;
        #1 release dut.overrun_cnt;
        step;
        repeat (30) step;
        @(negedge clk);
        chk("overrun saturates", {16'd0, overrun_cnt}, 32'd65535);
        chk("saturation tdata held", {16'd0, m_axis_tdata}, 32'd100);
        step;
        stop = 1'b1;
        step;
        stop = 1'b0;
        m_axis_tready = 1'b1;
        wait_done(50, "saturation stop");
        push_beats(4, 4);
        start_play(4, 1'b0);
        @(negedge clk);
        chk("overrun cleared on start", {16'd0, overrun_cnt}, 32'd0);
        step;
        wait_done(100, "post-saturation pass");
        chk("final leftover", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
